dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter (CPU and debug/loader port).
// One request is served at a time. A winner is chosen in IDLE, the DMEM
// access happens in ACCESS, and the result is returned in RESP. The CPU
// normally has priority, but the debug port gets a turn after MAX_BURST
// consecutive CPU wins while it is waiting. Address range, size and
// alignment are checked before the access, so an illegal command never
// reaches the memory.
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_uns,
    output logic        cpu_gnt,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [1:0]  dbg_size,
    input  logic        dbg_uns,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic        dm_ena,
    output logic        dm_r,
    output logic        dm_w,
    output logic [6:0]  dm_addr,
    output logic [31:0] dm_data_in,
    input  logic [31:0] dm_data_out,
    output logic        sb_flag,
    output logic        sh_flag,
    output logic        sw_flag,
    output logic        lb_flag,
    output logic        lh_flag,
    output logic        lbu_flag,
    output logic        lhu_flag,
    output logic        lw_flag
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    logic [1:0]  state;
    logic [3:0]  burst_cnt;

    // Latched command of the current winner
    logic        cmd_dbg;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [1:0]  cmd_size;
    logic        cmd_uns;
    logic [31:0] cap;

    logic        any_req;
    logic        dbg_wins;
    logic [31:0] offset;
    logic        illegal;

    assign any_req  = cpu_req | dbg_req;
    // Debug wins when alone, or when the CPU has used up its burst allowance
    assign dbg_wins = dbg_req & (~cpu_req | (burst_cnt >= BURST_LIMIT));
    // Wrap-around subtraction: addresses below the base become huge offsets
    assign offset   = cmd_addr - BASE_ADDR;

    // Command legality: range, illegal size code, half/word alignment
    always_comb begin
        illegal = 1'b0;
        if (offset[31:7] != 25'd0)
            illegal = 1'b1;
        if (cmd_size == 2'b11)
            illegal = 1'b1;
        if (cmd_size == 2'b01 && offset[0])
            illegal = 1'b1;
        if (cmd_size == 2'b10 && offset[1:0] != 2'b00)
            illegal = 1'b1;
    end

    // Transaction sequencing and CPU burst accounting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= ACCESS;
                        if (dbg_wins)
                            burst_cnt <= 4'd0;
                        else if (dbg_req) begin
                            if (burst_cnt != 4'hF)
                                burst_cnt <= burst_cnt + 4'd1;
                        end else
                            burst_cnt <= 4'd0;
                    end
                end
                ACCESS:  state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Command latch in IDLE and read-data capture at the end of ACCESS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_dbg   <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= 32'd0;
            cmd_wdata <= 32'd0;
            cmd_size  <= 2'd0;
            cmd_uns   <= 1'b0;
            cap       <= 32'd0;
        end else begin
            if (state == IDLE && any_req) begin
                cmd_dbg   <= dbg_wins;
                cmd_we    <= dbg_wins ? dbg_we    : cpu_we;
                cmd_addr  <= dbg_wins ? dbg_addr  : cpu_addr;
                cmd_wdata <= dbg_wins ? dbg_wdata : cpu_wdata;
                cmd_size  <= dbg_wins ? dbg_size  : cpu_size;
                cmd_uns   <= dbg_wins ? dbg_uns   : cpu_uns;
            end
            if (state == ACCESS)
                cap <= (!illegal && !cmd_we) ? dm_data_out : 32'd0;
        end
    end

    // Output decode: DMEM side only in ACCESS, requester side only in RESP
    always_comb begin
        dm_ena     = 1'b0;
        dm_r       = 1'b0;
        dm_w       = 1'b0;
        dm_addr    = 7'd0;
        dm_data_in = 32'd0;
        sb_flag    = 1'b0;
        sh_flag    = 1'b0;
        sw_flag    = 1'b0;
        lb_flag    = 1'b0;
        lh_flag    = 1'b0;
        lbu_flag   = 1'b0;
        lhu_flag   = 1'b0;
        lw_flag    = 1'b0;
        cpu_gnt    = 1'b0;
        cpu_rdata  = 32'd0;
        cpu_err    = 1'b0;
        dbg_gnt    = 1'b0;
        dbg_rdata  = 32'd0;
        dbg_err    = 1'b0;
        if (state == ACCESS && !illegal) begin
            dm_ena     = 1'b1;
            dm_r       = ~cmd_we;
            dm_w       = cmd_we;
            dm_addr    = offset[6:0];
            dm_data_in = cmd_wdata;
            if (cmd_we) begin
                case (cmd_size)
                    2'b00:   sb_flag = 1'b1;
                    2'b01:   sh_flag = 1'b1;
                    default: sw_flag = 1'b1;
                endcase
            end else begin
                case (cmd_size)
                    2'b00: begin
                        lbu_flag = cmd_uns;
                        lb_flag  = ~cmd_uns;
                    end
                    2'b01: begin
                        lhu_flag = cmd_uns;
                        lh_flag  = ~cmd_uns;
                    end
                    default: lw_flag = 1'b1;
                endcase
            end
        end
        if (state == RESP) begin
            if (cmd_dbg) begin
                dbg_gnt   = 1'b1;
                dbg_rdata = cap;
                dbg_err   = illegal;
            end else begin
                cpu_gnt   = 1'b1;
                cpu_rdata = cap;
                cpu_err   = illegal;
            end
        end
    end

endmodule
